// File: rtl/tile_engine.sv
// tile_engine: reads an N x N signed tile from SRAM A and SRAM B, applies
// MUL / ADD / SUB / DOT and writes the narrowed result tile (or a single
// dot-product word) to SRAM C.
// Optional feature macro: TILE_ENGINE_SAT_EN. When defined, results saturate
// on narrowing. When undefined, results keep their low DW bits (wrap).
module tile_engine #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] base_a,
    input  logic [AW-1:0] base_b,
    input  logic [AW-1:0] base_c,
    input  logic [AW-1:0] stride,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          a_re,
    output logic          b_re,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    input  logic [DW-1:0] a_dout,
    input  logic [DW-1:0] b_dout,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic [DW-1:0] c_din
);

    localparam int LOG2N = $clog2(N);
    localparam int NN    = N * N;
    localparam int IW    = 2 * LOG2N;
    localparam int ACCW  = 2 * DW + 2 * $clog2(N);

    localparam logic [IW-1:0]    LAST_IDX = IW'(NN - 1);
    localparam logic [LOG2N-1:0] COL_LAST = LOG2N'(N - 1);

    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_DOT = 2'd3;

`ifdef TILE_ENGINE_SAT_EN
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((1 << (DW - 1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-(1 << (DW - 1)));
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        EXEC,
        WRITE,
        DONE
    } state_t;

    state_t state;

    logic [1:0]    op_r;
    logic [AW-1:0] base_c_r;
    logic [AW-1:0] stride_r;
    logic [AW-1:0] row_a;
    logic [AW-1:0] row_b;
    logic [AW-1:0] row_c;
    logic [IW-1:0] rd_idx;
    logic          cap_valid;
    logic [IW-1:0] cap_idx;
    logic [IW-1:0] ex_idx;
    logic signed [ACCW-1:0] acc;

    logic [DW-1:0] tile_a [NN];
    logic [DW-1:0] tile_b [NN];

    logic [LOG2N-1:0] rd_col;
    logic [AW-1:0]    rd_col_next;
    logic [LOG2N-1:0] ex_i;
    logic [LOG2N-1:0] ex_j;
    logic [LOG2N-1:0] kk;
    logic signed [ACCW-1:0] mul_sum;
    logic signed [ACCW-1:0] ew_sum;
    logic signed [ACCW-1:0] ew_diff;
    logic signed [ACCW-1:0] dot_prod;
    logic signed [ACCW-1:0] exec_result;

    function automatic logic signed [ACCW-1:0] ext(input logic [DW-1:0] v);
        return {{(ACCW - DW){v[DW-1]}}, v};
    endfunction

    function automatic logic [DW-1:0] narrow(input logic signed [ACCW-1:0] v);
`ifdef TILE_ENGINE_SAT_EN
        if (v > SAT_MAX) return DW'(SAT_MAX);
        if (v < SAT_MIN) return DW'(SAT_MIN);
`endif
        return DW'(v);
    endfunction

    assign rd_col      = rd_idx[LOG2N-1:0];
    assign rd_col_next = AW'(rd_col) + AW'(1);
    assign ex_i        = ex_idx[IW-1:LOG2N];
    assign ex_j        = ex_idx[LOG2N-1:0];

    // Arithmetic for the element currently indexed in EXEC (N parallel MACs for MUL)
    always_comb begin
        mul_sum = '0;
        kk      = '0;
        for (int k = 0; k < N; k++) begin
            kk      = LOG2N'(k);
            mul_sum = mul_sum + ext(tile_a[{ex_i, kk}]) * ext(tile_b[{kk, ex_j}]);
        end
        ew_sum   = ext(tile_a[ex_idx]) + ext(tile_b[ex_idx]);
        ew_diff  = ext(tile_a[ex_idx]) - ext(tile_b[ex_idx]);
        dot_prod = ext(tile_a[ex_idx]) * ext(tile_b[ex_idx]);
        case (op_r)
            OP_ADD:  exec_result = ew_sum;
            OP_SUB:  exec_result = ew_diff;
            default: exec_result = mul_sum;
        endcase
    end

    // Capture SRAM read data into the local tiles one cycle after each read
    always_ff @(posedge clk) begin
        if (cap_valid) begin
            tile_a[cap_idx] <= a_dout;
            tile_b[cap_idx] <= b_dout;
        end
    end

    // Command FSM: owns every registered output, address walkers and the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_r      <= '0;
            base_c_r  <= '0;
            stride_r  <= '0;
            row_a     <= '0;
            row_b     <= '0;
            row_c     <= '0;
            rd_idx    <= '0;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            ex_idx    <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            a_re      <= 1'b0;
            b_re      <= 1'b0;
            a_addr    <= '0;
            b_addr    <= '0;
            c_we      <= 1'b0;
            c_addr    <= '0;
            c_din     <= '0;
        end else begin
            cap_valid <= a_re;
            cap_idx   <= rd_idx;
            c_we      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (stride < AW'(N)) begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            op_r     <= op;
                            base_c_r <= base_c;
                            stride_r <= stride;
                            row_a    <= base_a;
                            row_b    <= base_b;
                            a_addr   <= base_a;
                            b_addr   <= base_b;
                            a_re     <= 1'b1;
                            b_re     <= 1'b1;
                            rd_idx   <= '0;
                            state    <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (rd_idx == LAST_IDX) begin
                        a_re  <= 1'b0;
                        b_re  <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_idx <= rd_idx + IW'(1);
                        if (rd_col == COL_LAST) begin
                            row_a  <= row_a + stride_r;
                            row_b  <= row_b + stride_r;
                            a_addr <= row_a + stride_r;
                            b_addr <= row_b + stride_r;
                        end else begin
                            a_addr <= row_a + rd_col_next;
                            b_addr <= row_b + rd_col_next;
                        end
                    end
                end
                DRAIN: begin
                    ex_idx <= '0;
                    row_c  <= base_c_r;
                    acc    <= '0;
                    state  <= EXEC;
                end
                EXEC: begin
                    if (op_r == OP_DOT) begin
                        acc <= acc + dot_prod;
                    end else begin
                        c_we   <= 1'b1;
                        c_addr <= row_c + AW'(ex_j);
                        c_din  <= narrow(exec_result);
                    end
                    if (ex_j == COL_LAST) begin
                        row_c <= row_c + stride_r;
                    end
                    if (ex_idx == LAST_IDX) begin
                        state <= (op_r == OP_DOT) ? WRITE : DONE;
                    end else begin
                        ex_idx <= ex_idx + IW'(1);
                    end
                end
                WRITE: begin
                    c_we   <= 1'b1;
                    c_addr <= base_c_r;
                    c_din  <= narrow(acc);
                    state  <= DONE;
                end
                DONE: begin
                    if (done) begin
                        done  <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_engine.sv
// tb_tile_engine: table-driven bench for tile_engine (N=4, DW=8, AW=10) with
// SRAM models, a reference model feeding a write scoreboard, and hand-written
// sequences for reset during LOAD, held start and back-to-back commands.
module tb_tile_engine;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 10;

`ifdef TILE_ENGINE_SAT_EN
    localparam logic [7:0] ADD_EXP = 8'd127;
    localparam logic [7:0] DOT_EXP = 8'd127;
`else
    localparam logic [7:0] ADD_EXP = 8'h96;
    localparam logic [7:0] DOT_EXP = 8'h90;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = '0;
    logic [AW-1:0] base_a = '0;
    logic [AW-1:0] base_b = '0;
    logic [AW-1:0] base_c = '0;
    logic [AW-1:0] stride = '0;
    logic          busy, done, err, a_re, b_re, c_we;
    logic [AW-1:0] a_addr, b_addr, c_addr;
    logic [DW-1:0] a_dout = '0;
    logic [DW-1:0] b_dout = '0;
    logic [DW-1:0] c_din;

    logic [7:0] mem_a [1024];
    logic [7:0] mem_b [1024];

    typedef struct {
        logic [1:0] op;
        logic [9:0] ba;
        logic [9:0] bb;
        logic [9:0] bc;
        logic [9:0] stride;
        int         pat;
        bit         hold;
        bit         exp_err;
        int         exp_done;
        bit         chk_first;
        logic [7:0] first_data;
    } vec_t;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    vec_t vecs [9];
    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cur_vec = -1;

    tile_engine #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .base_a (base_a),
        .base_b (base_b),
        .base_c (base_c),
        .stride (stride),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .a_re   (a_re),
        .b_re   (b_re),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .a_dout (a_dout),
        .b_dout (b_dout),
        .c_we   (c_we),
        .c_addr (c_addr),
        .c_din  (c_din)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // SRAM A/B models with one-cycle read latency
    always @(posedge clk) begin
        if (a_re) a_dout <= mem_a[a_addr];
        if (b_re) b_dout <= mem_b[b_addr];
    end

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL vec%0d %s: got %0d, expected %0d", cur_vec, name, actual, expected);
        end
    endtask

    function automatic logic [7:0] narrow(input int v);
`ifdef TILE_ENGINE_SAT_EN
        if (v > 127) return 8'd127;
        if (v < -128) return 8'h80;
`endif
        return 8'(v);
    endfunction

    function automatic logic [9:0] elem_addr(input logic [9:0] base, input logic [9:0] str,
                                             input int r, input int c);
        return base + 10'(r) * str + 10'(c);
    endfunction

    // Place operand tiles into the SRAM models according to the vector's pattern
    task automatic fill_tiles(input vec_t v);
        logic [9:0] aa;
        logic [9:0] bb;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                aa = elem_addr(v.ba, v.stride, r, c);
                bb = elem_addr(v.bb, v.stride, r, c);
                case (v.pat)
                    0: begin mem_a[aa] = (r == c) ? 8'd1 : 8'd0; mem_b[bb] = 8'(r * 4 + c); end
                    1: begin mem_a[aa] = 8'd100; mem_b[bb] = 8'd50; end
                    2: begin mem_a[aa] = 8'd3; mem_b[bb] = 8'd3; end
                    default: begin mem_a[aa] = 8'($urandom); mem_b[bb] = 8'($urandom); end
                endcase
            end
        end
    endtask

    // Reference model: push every expected C write with its expected cycle
    task automatic push_expected(input vec_t v);
        int ta [16];
        int tb [16];
        int sum;
        exp_t e;
        if (v.exp_err) return;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ta[r * N + c] = int'($signed(mem_a[elem_addr(v.ba, v.stride, r, c)]));
                tb[r * N + c] = int'($signed(mem_b[elem_addr(v.bb, v.stride, r, c)]));
            end
        if (v.op == 2'd3) begin
            sum = 0;
            for (int k = 0; k < N * N; k++) sum += ta[k] * tb[k];
            e.addr = v.bc; e.data = narrow(sum); e.cyc = 2 * N * N + 3;
            sb.push_back(e);
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    case (v.op)
                        2'd1: sum = ta[i * N + j] + tb[i * N + j];
                        2'd2: sum = ta[i * N + j] - tb[i * N + j];
                        default: begin
                            sum = 0;
                            for (int k = 0; k < N; k++) sum += ta[i * N + k] * tb[k * N + j];
                        end
                    endcase
                    e.addr = elem_addr(v.bc, v.stride, i, j);
                    e.data = narrow(sum);
                    e.cyc  = N * N + 3 + i * N + j;
                    sb.push_back(e);
                end
        end
    endtask

    // Issue one command and monitor the DUT cycle by cycle until done
    task automatic apply_stimulus(input vec_t v);
        bit   seen_done;
        bit   first;
        bit   exp_re;
        int   e;
        exp_t x;
        fill_tiles(v);
        push_expected(v);
        @(posedge clk);
        #1;
        op = v.op; base_a = v.ba; base_b = v.bb; base_c = v.bc; stride = v.stride;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!v.hold) start = 1'b0;
        seen_done = 1'b0;
        first = 1'b1;
        for (int c = 1; c <= 100 && !seen_done; c++) begin
            @(negedge clk);
            exp_re = !v.exp_err && (c <= N * N);
            check_output("busy", int'(busy), 1);
            check_output("a_re", int'(a_re), int'(exp_re));
            check_output("b_re", int'(b_re), int'(exp_re));
            if (exp_re) begin
                e = c - 1;
                check_output("a_addr", int'(a_addr), int'(elem_addr(v.ba, v.stride, e / N, e % N)));
                check_output("b_addr", int'(b_addr), int'(elem_addr(v.bb, v.stride, e / N, e % N)));
            end
            if (c_we) begin
                if (sb.size() == 0) begin
                    check_output("c_we_unexpected", 1, 0);
                end else begin
                    x = sb.pop_front();
                    check_output("c_addr", int'(c_addr), int'(x.addr));
                    check_output("c_din", int'(c_din), int'(x.data));
                    check_output("c_we_cycle", c, x.cyc);
                    if (first && v.chk_first) check_output("c_din_const", int'(c_din), int'(v.first_data));
                    first = 1'b0;
                end
            end
            if (done) begin
                seen_done = 1'b1;
                check_output("done_cycle", c, v.exp_done);
                check_output("err", int'(err), int'(v.exp_err));
                check_output("writes_missing", sb.size(), 0);
                if (v.hold) start = 1'b0;
            end
        end
        if (!seen_done) check_output("done_timeout", 0, 1);
        sb.delete();
    endtask

    // Main sequence: reset state, vector table, reset during LOAD, recovery
    initial begin
        vecs[0] = '{2'd0, 10'd0,    10'd64,  10'd128, 10'd4, 0, 1'b0, 1'b0, 35, 1'b1, 8'd0};
        vecs[1] = '{2'd1, 10'd200,  10'd300, 10'd400, 10'd8, 1, 1'b0, 1'b0, 35, 1'b1, ADD_EXP};
        vecs[2] = '{2'd2, 10'd200,  10'd300, 10'd400, 10'd8, 1, 1'b0, 1'b0, 35, 1'b1, 8'd50};
        vecs[3] = '{2'd3, 10'd0,    10'd64,  10'd500, 10'd4, 2, 1'b0, 1'b0, 36, 1'b1, DOT_EXP};
        vecs[4] = '{2'd0, 10'd0,    10'd64,  10'd128, 10'd2, 0, 1'b0, 1'b1, 1,  1'b0, 8'd0};
        vecs[5] = '{2'd0, 10'd1020, 10'd600, 10'd1000, 10'd5, 3, 1'b0, 1'b0, 35, 1'b0, 8'd0};
        vecs[6] = '{2'd1, 10'd40,   10'd80,  10'd700, 10'd4, 3, 1'b1, 1'b0, 35, 1'b0, 8'd0};
        vecs[7] = '{2'd3, 10'd150,  10'd250, 10'd900, 10'd6, 3, 1'b0, 1'b0, 36, 1'b0, 8'd0};
        vecs[8] = '{2'd2, 10'd10,   10'd90,  10'd800, 10'd7, 3, 1'b1, 1'b0, 35, 1'b0, 8'd0};

        #2;
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_err", int'(err), 0);
        check_output("rst_a_re", int'(a_re), 0);
        check_output("rst_c_we", int'(c_we), 0);
        check_output("rst_c_addr", int'(c_addr), 0);
        check_output("rst_c_din", int'(c_din), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            cur_vec = i;
            apply_stimulus(vecs[i]);
        end

        cur_vec = 100;
        fill_tiles(vecs[0]);
        @(posedge clk);
        #1;
        op = 2'd0; base_a = 10'd0; base_b = 10'd64; base_c = 10'd128; stride = 10'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_output("mid_load_a_re", int'(a_re), 1);
        rst_n = 1'b0;
        #1;
        check_output("arst_busy", int'(busy), 0);
        check_output("arst_a_re", int'(a_re), 0);
        check_output("arst_b_re", int'(b_re), 0);
        check_output("arst_a_addr", int'(a_addr), 0);
        check_output("arst_b_addr", int'(b_addr), 0);
        check_output("arst_c_we", int'(c_we), 0);
        check_output("arst_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check_output("post_rst_a_re", int'(a_re), 0);
            check_output("post_rst_b_re", int'(b_re), 0);
            check_output("post_rst_c_we", int'(c_we), 0);
            check_output("post_rst_busy", int'(busy), 0);
        end

        cur_vec = 0;
        apply_stimulus(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
